// File: rtl/adc_decimator_if.sv
// Sample-in / Avalon-ST result-out bundle for adc_decimator.
// master = decimator side, slave = driver/sink side.
interface adc_decimator_if #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned ACC_W  = 24
);
  logic                     enable;
  logic [3:0]               log2_n;
  logic [DATA_W-1:0]        data_canal_a;
  logic [DATA_W-1:0]        data_canal_b;
  logic                     data_valid;
  logic                     clear_overflow;
  logic signed [ACC_W-1:0]  out_a;
  logic signed [ACC_W-1:0]  out_b;
  logic                     out_valid;
  logic                     out_ready;
  logic                     overflow;

  modport master (
    input  enable, log2_n, data_canal_a, data_canal_b, data_valid, clear_overflow, out_ready,
    output out_a, out_b, out_valid, overflow
  );

  modport slave (
    output enable, log2_n, data_canal_a, data_canal_b, data_valid, clear_overflow, out_ready,
    input  out_a, out_b, out_valid, overflow
  );
endinterface

// File: rtl/adc_decimator.sv
// Two-channel accumulate-and-dump decimator (2^log2_n samples per result, Avalon-ST out).
// Define ADC_OFFSET_BIN_EN to treat input samples as offset binary instead of two's complement.
module adc_decimator #(
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned MAX_LOG2_N = 10,
  parameter int unsigned ACC_W      = DATA_W + MAX_LOG2_N
) (
  input  logic               CLK_65,
  input  logic               reset,
  adc_decimator_if.master    io_bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [3:0] MaxExp = 4'(MAX_LOG2_N);

  state_e                  r_state;
  state_e                  w_state_d;
  logic [MAX_LOG2_N-1:0]   r_cnt;
  logic [3:0]              r_n_lat;
  logic signed [ACC_W-1:0] r_acc_a;
  logic signed [ACC_W-1:0] r_acc_b;
  logic signed [ACC_W-1:0] r_out_a;
  logic signed [ACC_W-1:0] r_out_b;
  logic                    r_out_valid;
  logic                    r_overflow;

  logic                    w_run;
  logic                    w_accept;
  logic                    w_done;
  logic                    w_load;
  logic                    w_drop;
  logic [3:0]              w_n_req;
  logic [3:0]              w_n_eff;
  logic [MAX_LOG2_N:0]     w_limit;
  logic                    w_last;
  logic [DATA_W-1:0]       w_raw_a;
  logic [DATA_W-1:0]       w_raw_b;
  logic signed [ACC_W-1:0] w_samp_a;
  logic signed [ACC_W-1:0] w_samp_b;
  logic signed [ACC_W-1:0] w_sum_a;
  logic signed [ACC_W-1:0] w_sum_b;

`ifdef ADC_OFFSET_BIN_EN
  assign w_raw_a = {~io_bus.data_canal_a[DATA_W-1], io_bus.data_canal_a[DATA_W-2:0]};
  assign w_raw_b = {~io_bus.data_canal_b[DATA_W-1], io_bus.data_canal_b[DATA_W-2:0]};
`else
  assign w_raw_a = io_bus.data_canal_a;
  assign w_raw_b = io_bus.data_canal_b;
`endif

  assign w_samp_a = {{(ACC_W-DATA_W){w_raw_a[DATA_W-1]}}, w_raw_a};
  assign w_samp_b = {{(ACC_W-DATA_W){w_raw_b[DATA_W-1]}}, w_raw_b};
  assign w_sum_a  = r_acc_a + w_samp_a;
  assign w_sum_b  = r_acc_b + w_samp_b;

  // The exponent in force is the live one on a block's first sample, the latched one after.
  assign w_n_req = (io_bus.log2_n > MaxExp) ? MaxExp : io_bus.log2_n;
  assign w_n_eff = (r_cnt == '0) ? w_n_req : r_n_lat;
  assign w_limit = ((MAX_LOG2_N+1)'(1) << w_n_eff) - (MAX_LOG2_N+1)'(1);
  assign w_last  = ({1'b0, r_cnt} == w_limit);

  always_ff @(posedge CLK_65) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (io_bus.enable)  w_state_d = StRun;
      StRun:   if (!io_bus.enable) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_run    = (r_state == StRun);
    w_accept = w_run && io_bus.enable && io_bus.data_valid;
    w_done   = w_accept && w_last;
    // A completing result may replace the held one only if that one leaves this cycle.
    w_load   = w_done && (!r_out_valid || io_bus.out_ready);
    w_drop   = w_done && r_out_valid && !io_bus.out_ready;
  end

  always_ff @(posedge CLK_65) begin
    if (reset) begin
      r_cnt       <= '0;
      r_n_lat     <= '0;
      r_acc_a     <= '0;
      r_acc_b     <= '0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_cnt == '0) r_n_lat <= w_n_req;
        if (w_last) begin
          r_acc_a <= '0;
          r_acc_b <= '0;
          r_cnt   <= '0;
        end else begin
          r_acc_a <= w_sum_a;
          r_acc_b <= w_sum_b;
          r_cnt   <= r_cnt + 1'b1;
        end
      end else if (!io_bus.enable) begin
        r_acc_a <= '0;
        r_acc_b <= '0;
        r_cnt   <= '0;
      end

      if (w_load) begin
        r_out_a     <= w_sum_a;
        r_out_b     <= w_sum_b;
        r_out_valid <= 1'b1;
      end else if (io_bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_drop)                     r_overflow <= 1'b1;
      else if (io_bus.clear_overflow) r_overflow <= 1'b0;
    end
  end

  assign io_bus.out_a     = r_out_a;
  assign io_bus.out_b     = r_out_b;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.overflow  = r_overflow;

endmodule
